// File: rtl/counter_pkg.sv
// Shared constants and helpers for the parameterised up/down counter.
package counter_pkg;

    // Encoding of the up_dn input.
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Number of bits needed to hold the values 0 .. value-1 (0 when value <= 1).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Register width for a counter covering 0 .. value-1; never narrower than one bit.
    function automatic int cnt_width(input int value);
        int w;
        w = clog2(value);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: issues one tick every PRESCALE enabled cycles. clr restarts the
// count from zero and suppresses the tick in that cycle.
module tick_gen
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = cnt_width(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    if (PRESCALE < 1 || PRESCALE > 256) begin : g_bad_prescale
        $error("tick_gen: PRESCALE must be in 1..256");
    end

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          at_last;

    assign at_last = (cnt_q == LAST);

    // The tick fires in the enabled cycle where the count sits at its last value.
    assign tick = en && !clr && at_last;

    // Next prescaler count: clear wins, otherwise advance only while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (at_last) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Prescaler count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/counter_updn_param.sv
// Parameterised up/down modulo-(MAX+1) counter with prescaler, load,
// optional saturation, combinational terminal count and registered carry.
module counter_updn_param
    import counter_pkg::*;
#(
    parameter int     WIDTH    = 4,
    parameter longint MAX      = (longint'(1) << WIDTH) - 1,
    parameter int     PRESCALE = 1,
    parameter int     SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             carry
);

    // Reject parameter sets that cannot be built.
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("counter_updn_param: WIDTH must be in 1..32");
    end
    if (MAX < 1 || MAX > ((longint'(1) << WIDTH) - 1)) begin : g_bad_max
        $error("counter_updn_param: MAX must be in 1..2**WIDTH-1");
    end
    if (PRESCALE < 1 || PRESCALE > 256) begin : g_bad_prescale
        $error("counter_updn_param: PRESCALE must be in 1..256");
    end
    if (SATURATE != 0 && SATURATE != 1) begin : g_bad_saturate
        $error("counter_updn_param: SATURATE must be 0 or 1");
    end

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    localparam bit               WRAP  = (SATURATE == 0);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             carry_q;
    logic             carry_d;

    logic             step;
    logic             at_max;
    logic             at_zero;
    logic             going_up;
    logic [WIDTH-1:0] load_clamped;

    // Prescaler; a load restarts it so the next step is a full period away.
    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clr   (load),
        .tick  (step)
    );

    assign at_max   = (q_q == MAX_V);
    assign at_zero  = (q_q == '0);
    assign going_up = (up_dn == DIR_UP);

    // Loads above MAX are clamped so q can never leave 0..MAX.
    assign load_clamped = (load_val > MAX_V) ? MAX_V : load_val;

    // Next count and carry: load beats a step; a wrap raises carry for one cycle.
    always_comb begin
        q_d     = q_q;
        carry_d = 1'b0;
        if (load) begin
            q_d = load_clamped;
        end else if (step) begin
            if (going_up) begin
                if (!at_max) begin
                    q_d = q_q + 1'b1;
                end else if (WRAP) begin
                    q_d     = '0;
                    carry_d = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    q_d = q_q - 1'b1;
                end else if (WRAP) begin
                    q_d     = MAX_V;
                    carry_d = 1'b1;
                end
            end
        end
    end

    // Count and carry registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q     <= '0;
            carry_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            carry_q <= carry_d;
        end
    end

    assign q     = q_q;
    assign carry = carry_q;

    // Terminal count follows up_dn immediately, with no register in the path.
    assign tc = going_up ? at_max : at_zero;

endmodule

// File: tb/tb_counter_updn_param.sv
// Bench for counter_updn_param: four instances with different MAX / PRESCALE /
// SATURATE settings share one stimulus stream; a behavioural model predicts
// each instance and a scoreboard queue holds the predictions until sampled.
module tb_counter_updn_param;

    localparam int N = 4;
    // Instance configs: 0 = full 4-bit wrap, 1 = mod-10 wrap, 2 = mod-10 /3 prescale, 3 = mod-10 saturating
    localparam int CFG_MAX [N] = '{15, 9, 9, 9};
    localparam int CFG_PRE [N] = '{1, 1, 3, 1};
    localparam int CFG_SAT [N] = '{0, 0, 0, 1};

    // ---------------- clock / reset ----------------
    logic       clk;
    logic       reset;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] load_val;

    logic [3:0] q_0, q_1, q_2, q_3;
    logic       tc_0, tc_1, tc_2, tc_3;
    logic       carry_0, carry_1, carry_2, carry_3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    counter_updn_param #(.WIDTH(4), .MAX(15), .PRESCALE(1), .SATURATE(0)) dut_0 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .q(q_0), .tc(tc_0), .carry(carry_0)
    );
    counter_updn_param #(.WIDTH(4), .MAX(9), .PRESCALE(1), .SATURATE(0)) dut_1 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .q(q_1), .tc(tc_1), .carry(carry_1)
    );
    counter_updn_param #(.WIDTH(4), .MAX(9), .PRESCALE(3), .SATURATE(0)) dut_2 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .q(q_2), .tc(tc_2), .carry(carry_2)
    );
    counter_updn_param #(.WIDTH(4), .MAX(9), .PRESCALE(1), .SATURATE(1)) dut_3 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .q(q_3), .tc(tc_3), .carry(carry_3)
    );

    // ---------------- model and scoreboard ----------------
    int         n_tests;
    int         n_fail;
    int         m_q     [N];
    int         m_ps    [N];
    int         m_carry [N];
    bit         m_valid [N];
    logic [19:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] get_q(input int i);
        case (i)
            0: return q_0;
            1: return q_1;
            2: return q_2;
            default: return q_3;
        endcase
    endfunction

    function automatic logic get_tc(input int i);
        case (i)
            0: return tc_0;
            1: return tc_1;
            2: return tc_2;
            default: return tc_3;
        endcase
    endfunction

    function automatic logic get_carry(input int i);
        case (i)
            0: return carry_0;
            1: return carry_1;
            2: return carry_2;
            default: return carry_3;
        endcase
    endfunction

    // Behavioural next-state of one instance for one clock edge.
    task automatic model_step(input int i, input bit r, input bit e, input bit ud,
                              input bit ld, input int lv);
        if (r) begin
            m_q[i] = 0; m_ps[i] = 0; m_carry[i] = 0; m_valid[i] = 1'b1;
        end else if (ld) begin
            m_q[i] = (lv > CFG_MAX[i]) ? CFG_MAX[i] : lv;
            m_ps[i] = 0; m_carry[i] = 0;
        end else begin
            m_carry[i] = 0;
            if (e) begin
                if (m_ps[i] == CFG_PRE[i] - 1) begin
                    m_ps[i] = 0;
                    if (ud) begin
                        if (m_q[i] < CFG_MAX[i]) m_q[i] = m_q[i] + 1;
                        else if (CFG_SAT[i] == 0) begin m_q[i] = 0; m_carry[i] = 1; end
                    end else begin
                        if (m_q[i] > 0) m_q[i] = m_q[i] - 1;
                        else if (CFG_SAT[i] == 0) begin m_q[i] = CFG_MAX[i]; m_carry[i] = 1; end
                    end
                end else begin
                    m_ps[i] = m_ps[i] + 1;
                end
            end
        end
    endtask

    // ---------------- driver ----------------
    // Called #1 after a rising edge: drive, check tc, predict, then sample after the next edge.
    task automatic drive_cycle(input bit r, input bit e, input bit ud, input bit ld, input logic [3:0] lv);
        logic [19:0] ent;
        reset = r; en = e; up_dn = ud; load = ld; load_val = lv;
        #1;
        for (int i = 0; i < N; i++) begin
            if (m_valid[i]) begin
                check_eq($sformatf("tc%0d", i), get_tc(i),
                         ud ? (m_q[i] == CFG_MAX[i]) : (m_q[i] == 0));
            end
        end
        ent = '0;
        for (int i = 0; i < N; i++) begin
            model_step(i, r, e, ud, ld, int'(lv));
            ent[i*5 +: 5] = {4'(m_q[i]), 1'(m_carry[i])};
        end
        exp_q.push_back(ent);
        @(posedge clk);
        #1;
        ent = exp_q.pop_front();
        for (int i = 0; i < N; i++) begin
            check_eq($sformatf("q%0d", i), get_q(i), ent[i*5+1 +: 4]);
            check_eq($sformatf("carry%0d", i), get_carry(i), ent[i*5]);
            check_eq($sformatf("q%0d_le_max", i), get_q(i) <= 4'(CFG_MAX[i]), 1);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < N; i++) begin
            m_q[i] = 0; m_ps[i] = 0; m_carry[i] = 0; m_valid[i] = 1'b0;
        end
        reset = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 4'd0;
        @(posedge clk);
        #1;

        // Reset with en and load active: reset must win.
        drive_cycle(1, 1, 1, 1, 4'd5);
        drive_cycle(1, 0, 0, 0, 4'd0);
        check_eq("rst_q0", q_0, 0);
        check_eq("rst_carry0", carry_0, 0);
        check_eq("rst_tc_down", tc_1, 1);

        // Full-range up count: 0..15, 0, 1 on instance 0.
        for (int k = 0; k < 17; k++) begin
            drive_cycle(0, 1, 1, 0, 4'd0);
            if (k == 14) check_eq("up_tc_at15", tc_0, 1);
            if (k == 15) check_eq("up_wrap_carry", carry_0, 1);
        end
        check_eq("up_after17", q_0, 1);
        check_eq("up_carry_gone", carry_0, 0);

        // Mod-10 down count from reset: 9, 8 .. 0, 9 on instance 1.
        drive_cycle(1, 0, 0, 0, 4'd0);
        for (int k = 0; k < 11; k++) begin
            drive_cycle(0, 1, 0, 0, 4'd0);
            if (k == 0) check_eq("dn_first_wrap", q_1, 9);
        end
        check_eq("dn_back_to_9", q_1, 9);
        check_eq("dn_borrow", carry_1, 1);

        // Prescale 3 with en pattern 1,1,0,1.
        drive_cycle(1, 0, 1, 0, 4'd0);
        drive_cycle(0, 1, 1, 0, 4'd0);
        drive_cycle(0, 1, 1, 0, 4'd0);
        check_eq("pre_no_step_yet", q_2, 0);
        drive_cycle(0, 0, 1, 0, 4'd0);
        check_eq("pre_hold_en0", q_2, 0);
        drive_cycle(0, 1, 1, 0, 4'd0);
        check_eq("pre_first_step", q_2, 1);

        // Load above MAX clamps; load beats a wrapping step.
        drive_cycle(0, 0, 1, 1, 4'd12);
        check_eq("load_clamp", q_1, 9);
        check_eq("load_wide", q_0, 12);
        drive_cycle(0, 1, 1, 1, 4'd3);
        check_eq("load_wins_q", q_1, 3);
        check_eq("load_wins_carry", carry_1, 0);

        // Saturation at MAX for 5 steps, then one step down.
        drive_cycle(0, 0, 1, 1, 4'd9);
        for (int k = 0; k < 5; k++) drive_cycle(0, 1, 1, 0, 4'd0);
        check_eq("sat_hold", q_3, 9);
        check_eq("sat_no_carry", carry_3, 0);
        drive_cycle(0, 1, 0, 0, 4'd0);
        check_eq("sat_down", q_3, 8);

        // Reset mid-count at q=7 with the prescaler part-way.
        drive_cycle(0, 0, 1, 1, 4'd7);
        drive_cycle(0, 1, 1, 0, 4'd0);
        check_eq("mid_q_before", q_2, 7);
        drive_cycle(1, 1, 1, 0, 4'd0);
        check_eq("mid_rst_q", q_2, 0);
        check_eq("mid_rst_carry", carry_2, 0);
        drive_cycle(0, 1, 1, 0, 4'd0);
        drive_cycle(0, 1, 1, 0, 4'd0);
        check_eq("mid_no_step", q_2, 0);
        drive_cycle(0, 1, 1, 0, 4'd0);
        check_eq("mid_first_step", q_2, 1);

        // Random traffic, including direction flips mid-prescale.
        for (int k = 0; k < 400; k++) begin
            drive_cycle($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
                        1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0,
                        4'($urandom_range(0, 15)));
        end

        check_eq("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
